// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory, redirect and decode handshake bundle for fetch_sequencer.
interface fetch_sequencer_if #(parameter int XLEN = 32);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     fetch_count;
  logic            misalign_fault;
  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_count, misalign_fault,
    input  imem_ack, imem_rdata, redirect_valid, redirect_target, if_ready
  );
  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_count, misalign_fault,
    output imem_ack, imem_rdata, redirect_valid, redirect_target, if_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner issuing one imem request at a time, holding each word until decode takes it.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirects into a sticky FAULT state instead of masking them.
module fetch_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic               clock,
  input logic               reset,
  fetch_sequencer_if.master bus
);
  typedef enum logic [1:0] {FETCH, VALID, DRAIN, FAULT} state_t;
  state_t          state_q;
  logic [XLEN-1:0] pc_q, req_addr_q, if_pc_q, tgt;
  logic [31:0]     instr_q, cnt_q;
  logic            valid_q, fault_q, bad, redir;
`ifdef FETCH_ALIGN_CHECK_EN
  assign bad = bus.redirect_valid && bus.redirect_target[1:0] != 2'b00;
  assign tgt = bus.redirect_target;
`else
  assign bad = 1'b0;
  assign tgt = {bus.redirect_target[XLEN-1:2], 2'b00};
`endif
  assign redir = bus.redirect_valid && !bad;
  // Gating with reset keeps the port quiet while reset is held, before the first post-reset request.
  assign bus.imem_req       = !reset && (state_q == FETCH || state_q == DRAIN);
  assign bus.imem_addr      = state_q == DRAIN ? req_addr_q : pc_q;
  assign bus.if_valid       = valid_q;
  assign bus.if_instr       = instr_q;
  assign bus.if_pc          = if_pc_q;
  assign bus.fetch_count    = cnt_q;
  assign bus.misalign_fault = fault_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      if_pc_q    <= '0;
      instr_q    <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          req_addr_q <= pc_q;
          if (bad) begin
            fault_q <= 1'b1;
            state_q <= bus.imem_ack ? FAULT : DRAIN;
          end else if (redir) begin
            pc_q <= tgt;
            if (!bus.imem_ack) state_q <= DRAIN;
          end else if (bus.imem_ack) begin
            instr_q <= bus.imem_rdata;
            if_pc_q <= pc_q;
            pc_q    <= pc_q + XLEN'(4);
            valid_q <= 1'b1;
            state_q <= VALID;
          end
        end
        VALID: begin
          if (bad) begin
            fault_q <= 1'b1;
            valid_q <= 1'b0;
            state_q <= FAULT;
          end else if (redir) begin
            pc_q    <= tgt;
            valid_q <= 1'b0;
            state_q <= FETCH;
          end else if (bus.if_ready) begin
            cnt_q   <= cnt_q + 32'd1;
            valid_q <= 1'b0;
            state_q <= FETCH;
          end
        end
        DRAIN: begin
          // Once a fault is pending the PC is frozen; only the stale ack is awaited.
          if (bad) fault_q <= 1'b1;
          else if (redir && !fault_q) pc_q <= tgt;
          if (bus.imem_ack) state_q <= (fault_q || bad) ? FAULT : FETCH;
        end
        default: ;
      endcase
    end
  end
endmodule
